// File: rtl/sd_cmd_pkg.sv
// Shared encodings for the SD command-line PHY sequencer.
// Defining SD_CMD_RETRY_EN adds the RETRY state.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_LOAD_COMMAND,
        S_SEND_COMMAND,
        S_WAIT_RESPONSE,
`ifdef SD_CMD_RETRY_EN
        S_RETRY,
`endif
        S_SEND_RESPONSE,
        S_WAIT_ACK
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE     = 2'd0,
        RESP_SHORT    = 2'd1,
        RESP_LONG     = 2'd2,
        RESP_LONG_ALT = 2'd3
    } resp_type_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_ABORTED  = 2'd2,
        ST_RESERVED = 2'd3
    } status_t;

    typedef struct packed {
        logic pad_state;
        logic pad_enable;
        logic enable_pts;
        logic enable_stp;
        logic reset_wrapper;
    } pad_ctrl_t;

    // Wrapper control pattern that belongs to each state.
    function automatic pad_ctrl_t pad_ctrl(input state_t s);
        case (s)
            S_LOAD_COMMAND,
            S_SEND_COMMAND:  pad_ctrl = pad_ctrl_t'(5'b11100);
            S_WAIT_RESPONSE: pad_ctrl = pad_ctrl_t'(5'b01010);
            S_RESET,
            S_IDLE:          pad_ctrl = pad_ctrl_t'(5'b00001);
`ifdef SD_CMD_RETRY_EN
            S_RETRY:         pad_ctrl = pad_ctrl_t'(5'b00001);
`endif
            default:         pad_ctrl = pad_ctrl_t'(5'b00000);
        endcase
    endfunction

    function automatic logic is_long(input logic [1:0] resp_type);
        return resp_type[1];
    endfunction

endpackage

// File: rtl/sd_cmd_timeout_cnt.sv
// Response timeout counter: clearable, enableable, saturates at TIMEOUT_CYC-1
// and flags that terminal value.
module sd_cmd_timeout_cnt
    import sd_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic sd_clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge sd_clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/sd_cmd_phy_sequencer.sv
// SD CMD-line sequencer: host strobe/ack handshake, PTS/STP wrapper control,
// response timeout; retry on timeout when SD_CMD_RETRY_EN is defined.
module sd_cmd_phy_sequencer
    import sd_cmd_pkg::*;
#(
    parameter int unsigned CMD_W       = 48,
    parameter int unsigned RESP_W      = 136,
    parameter int unsigned SHORT_W     = 48,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              strobe_in,
    input  logic              ack_in,
    input  logic              idle_in,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic [1:0]        resp_type_in,
    output logic              ack_out,
    output logic              strobe_out,
    output logic [RESP_W-1:0] response,
    output logic [1:0]        status,
    input  logic [RESP_W-1:0] pad_response,
    input  logic              transmission_complete,
    input  logic              reception_complete,
    output logic [CMD_W-1:0]  cmd_out,
    output logic              resp_long,
    output logic              reset_wrapper,
    output logic              pad_state,
    output logic              pad_enable,
    output logic              enable_pts_wrapper,
    output logic              enable_stp_wrapper
);

    if (TIMEOUT_CYC < 2 || SHORT_W > RESP_W || MAX_RETRY > 255) begin : g_param_check
        $error("sd_cmd_phy_sequencer: unsupported parameter set");
    end

    state_t     state;
    pad_ctrl_t  ctrl;
    logic [1:0] resp_type_q;
    logic       timeout;

`ifdef SD_CMD_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0] retry_cnt;
`endif

    sd_cmd_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (state != S_WAIT_RESPONSE),
        .enable   (state == S_WAIT_RESPONSE),
        .terminal (timeout)
    );

    assign {pad_state, pad_enable, enable_pts_wrapper, enable_stp_wrapper, reset_wrapper} = ctrl;
    assign ack_out = ack_in && (state == S_WAIT_ACK);

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state       <= S_RESET;
            ctrl        <= pad_ctrl(S_RESET);
            cmd_out     <= '0;
            resp_type_q <= RESP_NONE;
            resp_long   <= 1'b0;
            response    <= '0;
            status      <= ST_OK;
            strobe_out  <= 1'b0;
`ifdef SD_CMD_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else if (idle_in) begin
            state      <= S_IDLE;
            ctrl       <= pad_ctrl(S_IDLE);
            response   <= '0;
            status     <= ST_OK;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= 1'b0;
            case (state)
                S_RESET: begin
                    state <= S_IDLE;
                    ctrl  <= pad_ctrl(S_IDLE);
                end
                S_IDLE: begin
                    if (strobe_in) begin
                        cmd_out     <= cmd_in;
                        resp_type_q <= resp_type_in;
                        resp_long   <= is_long(resp_type_in);
`ifdef SD_CMD_RETRY_EN
                        retry_cnt   <= '0;
`endif
                        state       <= S_LOAD_COMMAND;
                        ctrl        <= pad_ctrl(S_LOAD_COMMAND);
                    end
                end
                S_LOAD_COMMAND: begin
                    state <= S_SEND_COMMAND;
                    ctrl  <= pad_ctrl(S_SEND_COMMAND);
                end
                S_SEND_COMMAND: begin
                    if (transmission_complete) begin
                        if (resp_type_q != RESP_NONE) begin
                            state <= S_WAIT_RESPONSE;
                            ctrl  <= pad_ctrl(S_WAIT_RESPONSE);
                        end else begin
                            response   <= '0;
                            status     <= ST_OK;
                            strobe_out <= 1'b1;
                            state      <= S_SEND_RESPONSE;
                            ctrl       <= pad_ctrl(S_SEND_RESPONSE);
                        end
                    end
                end
                S_WAIT_RESPONSE: begin
                    // Reception is tested first so it beats a same-cycle timeout.
                    if (reception_complete) begin
                        response   <= resp_long ? pad_response
                                                : RESP_W'(pad_response[SHORT_W-1:0]);
                        status     <= ST_OK;
                        strobe_out <= 1'b1;
                        state      <= S_SEND_RESPONSE;
                        ctrl       <= pad_ctrl(S_SEND_RESPONSE);
                    end else if (timeout) begin
`ifdef SD_CMD_RETRY_EN
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            state <= S_RETRY;
                            ctrl  <= pad_ctrl(S_RETRY);
                        end else
`endif
                        begin
                            response   <= '0;
                            status     <= ST_TIMEOUT;
                            strobe_out <= 1'b1;
                            state      <= S_SEND_RESPONSE;
                            ctrl       <= pad_ctrl(S_SEND_RESPONSE);
                        end
                    end
                end
`ifdef SD_CMD_RETRY_EN
                S_RETRY: begin
                    retry_cnt <= retry_cnt + 1'b1;
                    state     <= S_LOAD_COMMAND;
                    ctrl      <= pad_ctrl(S_LOAD_COMMAND);
                end
`endif
                S_SEND_RESPONSE: begin
                    state <= S_WAIT_ACK;
                    ctrl  <= pad_ctrl(S_WAIT_ACK);
                end
                S_WAIT_ACK: begin
                    if (ack_in) begin
                        state <= S_IDLE;
                        ctrl  <= pad_ctrl(S_IDLE);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ctrl  <= pad_ctrl(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_phy_sequencer.sv
// Scoreboard bench for sd_cmd_phy_sequencer; follows SD_CMD_RETRY_EN if defined.
module tb_sd_cmd_phy_sequencer;

    localparam int CMD_W = 48;
    localparam int RW    = 136;
    localparam int SW    = 48;
    localparam int TMO   = 64;
    localparam int MAXR  = 2;

    logic            sd_clock = 1'b0;
    logic            reset = 1'b1;
    logic            strobe_in = 1'b0;
    logic            ack_in = 1'b0;
    logic            idle_in = 1'b0;
    logic [CMD_W-1:0] cmd_in = '0;
    logic [1:0]      resp_type_in = 2'd0;
    logic            ack_out;
    logic            strobe_out;
    logic [RW-1:0]   response;
    logic [1:0]      status;
    logic [RW-1:0]   pad_response = '0;
    logic            transmission_complete = 1'b0;
    logic            reception_complete = 1'b0;
    logic [CMD_W-1:0] cmd_out;
    logic            resp_long;
    logic            reset_wrapper;
    logic            pad_state;
    logic            pad_enable;
    logic            enable_pts_wrapper;
    logic            enable_stp_wrapper;

    sd_cmd_phy_sequencer #(
        .CMD_W(CMD_W), .RESP_W(RW), .SHORT_W(SW), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
    ) dut (
        .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
        .idle_in(idle_in), .cmd_in(cmd_in), .resp_type_in(resp_type_in),
        .ack_out(ack_out), .strobe_out(strobe_out), .response(response), .status(status),
        .pad_response(pad_response), .transmission_complete(transmission_complete),
        .reception_complete(reception_complete), .cmd_out(cmd_out), .resp_long(resp_long),
        .reset_wrapper(reset_wrapper), .pad_state(pad_state), .pad_enable(pad_enable),
        .enable_pts_wrapper(enable_pts_wrapper), .enable_stp_wrapper(enable_stp_wrapper)
    );

    typedef struct {
        logic [RW-1:0] resp;
        logic [1:0]    stat;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   stp_seen = 1'b0;
    bit   prev_strobe = 1'b0;

    localparam logic [RW-1:0] PAD_SHORT = 136'hA5A5A5A5A5A5A5A5A5A5A5_3F00FF8080FF;
    localparam logic [RW-1:0] EXP_SHORT = 136'h3F00FF8080FF;
    localparam logic [RW-1:0] PAD_LONG1 = 136'h0123456789ABCDEF_FEDCBA9876543210_C3;
    localparam logic [RW-1:0] PAD_LONG2 = 136'h3F_00112233445566778899AABBCCDDEEFF;

    always #5 sd_clock = ~sd_clock;
    always @(posedge sd_clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic push(input logic [RW-1:0] r, input logic [1:0] s, input int c);
        exp_t e;
        e.resp = r;
        e.stat = s;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic pulse_txc();
        transmission_complete = 1'b1;
        tick();
        transmission_complete = 1'b0;
    endtask

    task automatic pulse_rxc(input logic [RW-1:0] pad);
        pad_response = pad;
        reception_complete = 1'b1;
        tick();
        reception_complete = 1'b0;
    endtask

    task automatic issue(input logic [CMD_W-1:0] c, input logic [1:0] t);
        cmd_in       = c;
        resp_type_in = t;
        strobe_in    = 1'b1;
        tick();
        strobe_in    = 1'b0;
        chk("pts_latency", enable_pts_wrapper, 1);
        chk("cmd_latched", cmd_out, c);
        chk("resp_long", resp_long, t[1]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s strobe_out wait expired pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_ack(input logic [RW-1:0] held);
        chk("resp_held", response, held);
        ack_in = 1'b1;
        #1;
        chk("ack_out_wait_ack", ack_out, 1);
        tick();
        ack_in = 1'b0;
        chk("idle_after_ack", reset_wrapper, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents strobe_out.
    initial begin
        forever begin
            @(negedge sd_clock);
            if (enable_stp_wrapper) stp_seen = 1'b1;
            if (prev_strobe) chk("strobe_one_cycle", strobe_out, 0);
            prev_strobe = strobe_out;
            if (strobe_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("response", response, e.resp);
                    chk("status", status, e.stat);
                    chk("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_reset_wrapper", reset_wrapper, 1);
        chk("rst_strobe_out", strobe_out, 0);
        chk("rst_response", response, 0);
        chk("rst_status", status, 0);
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_pad_ctrl", {pad_state, pad_enable, enable_pts_wrapper, enable_stp_wrapper}, 0);
        chk("rst_resp_long", resp_long, 0);
        reset = 1'b0;
        repeat (2) tick();

        ack_in = 1'b1;
        #1;
        chk("ack_out_idle", ack_out, 0);
        ack_in = 1'b0;

        // Short response
        issue(48'h400000000095, 2'd1);
        repeat (47) tick();
        pulse_txc();
        chk("wait_stp", enable_stp_wrapper, 1);
        cmd_in    = 48'h7FFFFFFFFFFF;
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        chk("strobe_ignored", cmd_out, 48'h400000000095);
        repeat (8) tick();
        push(EXP_SHORT, 2'd0, cyc + 1);
        pulse_rxc(PAD_SHORT);
        wait_drain("short");
        do_ack(EXP_SHORT);

        // No-response command
        stp_seen = 1'b0;
        issue(48'h000000000001, 2'd0);
        repeat (5) tick();
        push('0, 2'd0, cyc + 1);
        pulse_txc();
        wait_drain("none");
        chk("no_stp_enable", stp_seen, 0);
        do_ack('0);

        // Long, never answered
        issue(48'h480000010A5B, 2'd2);
        repeat (3) tick();
`ifdef SD_CMD_RETRY_EN
        for (int r = 0; r < MAXR; r++) begin
            pulse_txc();
            repeat (TMO - 1) tick();
            chk("retry_wait_span", enable_stp_wrapper, 1);
            tick();
            chk("retry_reset_wrapper", reset_wrapper, 1);
            tick();
            chk("retry_reload", enable_pts_wrapper, 1);
            tick();
        end
`endif
        pulse_txc();
        repeat (TMO - 1) tick();
        chk("wait_span", enable_stp_wrapper, 1);
        push('0, 2'd1, cyc + 1);
        wait_drain("timeout");
        do_ack('0);

`ifdef SD_CMD_RETRY_EN
        // Answered on the second attempt
        issue(48'h4D0000000011, 2'd1);
        tick();
        pulse_txc();
        repeat (TMO) tick();
        chk("retry_once", reset_wrapper, 1);
        repeat (2) tick();
        pulse_txc();
        repeat (5) tick();
        push(EXP_SHORT, 2'd0, cyc + 1);
        pulse_rxc(PAD_SHORT);
        wait_drain("retry_success");
        do_ack(EXP_SHORT);
`endif

        // Type 3 answered on the timeout cycle itself
        issue(48'h420000000011, 2'd3);
        repeat (2) tick();
        pulse_txc();
        repeat (TMO - 1) tick();
        push(PAD_LONG1, 2'd0, cyc + 1);
        pulse_rxc(PAD_LONG1);
        wait_drain("rx_at_timeout");
        do_ack(PAD_LONG1);

        // Abort while sending
        issue(48'h5A0000000033, 2'd1);
        tick();
        idle_in = 1'b1;
        tick();
        idle_in = 1'b0;
        chk("abort_idle", reset_wrapper, 1);
        chk("abort_pts_off", enable_pts_wrapper, 0);
        chk("abort_resp_clear", response, 0);
        repeat (2) tick();
        pulse_txc();
        tick();
        chk("abort_no_wait", enable_stp_wrapper, 0);

        // Reset while waiting for ack
        issue(48'h490000000077, 2'd2);
        repeat (3) tick();
        pulse_txc();
        repeat (4) tick();
        push(PAD_LONG2, 2'd0, cyc + 1);
        pulse_rxc(PAD_LONG2);
        wait_drain("long");
        reset  = 1'b1;
        ack_in = 1'b1;
        tick();
        chk("rstack_reset_wrapper", reset_wrapper, 1);
        chk("rstack_response", response, 0);
        chk("rstack_status", status, 0);
        chk("rstack_cmd_out", cmd_out, 0);
        chk("rstack_resp_long", resp_long, 0);
        chk("rstack_ack_out", ack_out, 0);
        chk("rstack_pad_ctrl", {pad_state, pad_enable, enable_pts_wrapper, enable_stp_wrapper}, 0);
        reset  = 1'b0;
        ack_in = 1'b0;

        repeat (5) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
